row_serializer: RTL and testbench

Parallel-to-serial converter that unloads an N-element row of NUM_BITS words onto a single-word valid/ready stream. It is the transmit end of the element stream consumed by the C-array shift accumulator: words are emitted highest index first, so N accepted beats rebuild the row in the same index order on the receive side. It sits between the row buffer and any single-word consumer, including the accumulator's `C_i`/`valid_i` input.

---
 rtl/row_serializer_pkg.sv | 16 +
 rtl/row_serializer.sv | 78 +++++++
 tb/tb_row_serializer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/row_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | row_serializer_pkg                                                   |
// | Row geometry and state encoding shared by the row serializer.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package row_serializer_pkg;

  localparam int N        = 4;
  localparam int NUM_BITS = 8;
  localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, STREAM} ser_state_e;

endpackage
`default_nettype wire

// File: rtl/row_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | row_serializer                                                       |
// | Unloads an N-element row onto a single-word valid/ready stream,      |
// | highest index first.                                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module row_serializer
  import row_serializer_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N-1:0][NUM_BITS-1:0]   row_i,
  input  logic                         load_valid_i,
  output logic                         load_ready_o,
  output logic [NUM_BITS-1:0]          elem_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         last_o,
  output logic                         busy_o
);

  ser_state_e                  r_state;
  ser_state_e                  w_state_nxt;
  logic [N-1:0][NUM_BITS-1:0]  r_buf;
  logic [CNT_W-1:0]            r_remaining;
  logic                        w_last;
  logic                        w_fire;
  logic                        w_load_ready;
  logic                        w_load;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ready reopens on the accepted last beat so rows can follow with no bubble.
  always_comb begin
    w_last       = (r_state == STREAM) && (r_remaining == '0);
    w_fire       = (r_state == STREAM) && ready_i;
    w_load_ready = (r_state == IDLE) || (w_fire && w_last);
    w_load       = load_valid_i && w_load_ready;
    w_state_nxt  = r_state;
    if (w_load) begin
      w_state_nxt = STREAM;
    end else if (w_fire && w_last) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_buf       <= '0;
      r_remaining <= '0;
    end else if (w_load) begin
      r_buf       <= row_i;
      r_remaining <= CNT_W'(N - 1);
    end else if (w_fire) begin
      if (w_last) begin
        r_buf <= '0;
      end else begin
        r_buf       <= {r_buf[N-2:0], {NUM_BITS{1'b0}}};
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  assign elem_o       = r_buf[N-1];
  assign valid_o      = (r_state == STREAM);
  assign last_o       = w_last;
  assign busy_o       = (r_state == STREAM);
  assign load_ready_o = w_load_ready;

endmodule
`default_nettype wire

// File: tb/tb_row_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_row_serializer                                                    |
// | Vector table, corner sequences and random stimulus vs. queue model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_row_serializer;
  import row_serializer_pkg::*;

  typedef logic [N-1:0][NUM_BITS-1:0] row_t;

  typedef struct {
    logic                lv;
    logic                rdy;
    row_t                row;
    logic                ev;
    logic [NUM_BITS-1:0] ee;
    logic                el;
    logic                elr;
    logic                eb;
  } vec_t;

  logic                clk_i = 1'b0;
  logic                rst_i;
  row_t                row_i;
  logic                load_valid_i;
  logic                load_ready_o;
  logic [NUM_BITS-1:0] elem_o;
  logic                valid_o;
  logic                ready_i;
  logic                last_o;
  logic                busy_o;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  row_t prod;

  row_serializer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .row_i        (row_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .elem_o       (elem_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .last_o       (last_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in for the accumulator's shift register: newest word enters at index 0.
  always @(posedge clk_i) begin
    if (valid_o && ready_i) prod <= {prod[N-2:0], elem_o};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [NUM_BITS-1:0] ee,
                            input logic el, input logic elr, input logic eb);
    check({tag, " valid"}, 64'(valid_o), 64'(ev));
    check({tag, " elem"}, 64'(elem_o), 64'(ee));
    check({tag, " last"}, 64'(last_o), 64'(el));
    check({tag, " load_ready"}, 64'(load_ready_o), 64'(elr));
    check({tag, " busy"}, 64'(busy_o), 64'(eb));
  endtask

  function automatic void add(input logic lv, input logic rdy, input row_t row,
                              input logic ev, input logic [NUM_BITS-1:0] ee,
                              input logic el, input logic elr, input logic eb);
    vec_t v;
    v.lv = lv; v.rdy = rdy; v.row = row;
    v.ev = ev; v.ee = ee; v.el = el; v.elr = elr; v.eb = eb;
    vecs.push_back(v);
  endfunction

  initial begin
    row_t r_basic, r_alt, r_a, r_b, r_new, r_e2e;
    logic [NUM_BITS-1:0] pend[$];
    row_t cur_row, done_row;
    logic ev, el, elr, fin;
    logic [NUM_BITS-1:0] ee;

    r_basic = 32'h04030201;
    r_alt   = 32'hEEDDCCBB;
    r_a     = 32'hA3A2A1A0;
    r_b     = 32'hB3B2B1B0;
    r_new   = 32'h5D5C5B5A;
    r_e2e   = 32'h44332211;

    // Basic row
    add(1, 1, r_basic, 0, 8'h00, 0, 1, 0);
    add(0, 1, '0,      1, 8'h04, 0, 0, 1);
    add(0, 1, '0,      1, 8'h03, 0, 0, 1);
    add(0, 1, '0,      1, 8'h02, 0, 0, 1);
    add(0, 1, '0,      1, 8'h01, 1, 1, 1);
    add(0, 1, '0,      0, 8'h00, 0, 1, 0);
    // Back-pressure for three cycles after the 0x03 beat
    add(1, 1, r_basic, 0, 8'h00, 0, 1, 0);
    add(0, 1, '0,      1, 8'h04, 0, 0, 1);
    add(0, 1, '0,      1, 8'h03, 0, 0, 1);
    add(0, 0, '0,      1, 8'h02, 0, 0, 1);
    add(0, 0, '0,      1, 8'h02, 0, 0, 1);
    add(0, 0, '0,      1, 8'h02, 0, 0, 1);
    add(0, 1, '0,      1, 8'h02, 0, 0, 1);
    add(0, 1, '0,      1, 8'h01, 1, 1, 1);
    add(0, 1, '0,      0, 8'h00, 0, 1, 0);
    // Ignored load during the second beat
    add(1, 1, r_basic, 0, 8'h00, 0, 1, 0);
    add(0, 1, '0,      1, 8'h04, 0, 0, 1);
    add(1, 1, r_alt,   1, 8'h03, 0, 0, 1);
    add(0, 1, '0,      1, 8'h02, 0, 0, 1);
    add(0, 1, '0,      1, 8'h01, 1, 1, 1);
    add(0, 1, '0,      0, 8'h00, 0, 1, 0);
    // Back-to-back rows A then B
    add(1, 1, r_a, 0, 8'h00, 0, 1, 0);
    add(1, 1, r_b, 1, 8'hA3, 0, 0, 1);
    add(1, 1, r_b, 1, 8'hA2, 0, 0, 1);
    add(1, 1, r_b, 1, 8'hA1, 0, 0, 1);
    add(1, 1, r_b, 1, 8'hA0, 1, 1, 1);
    add(0, 1, '0,  1, 8'hB3, 0, 0, 1);
    add(0, 1, '0,  1, 8'hB2, 0, 0, 1);
    add(0, 1, '0,  1, 8'hB1, 0, 0, 1);
    add(0, 1, '0,  1, 8'hB0, 1, 1, 1);
    add(0, 1, '0,  0, 8'h00, 0, 1, 0);

    rst_i = 1'b1;
    load_valid_i = 1'b0;
    ready_i = 1'b0;
    row_i = '0;
    step();
    step();
    check_outs("reset", 0, '0, 0, 1, 0);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      load_valid_i = vecs[i].lv;
      ready_i      = vecs[i].rdy;
      row_i        = vecs[i].row;
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ee, vecs[i].el, vecs[i].elr, vecs[i].eb);
      step();
    end

    // Mid-row reset after two beats, then a fresh row
    load_valid_i = 1'b1; ready_i = 1'b1; row_i = r_basic;
    step();
    load_valid_i = 1'b0; row_i = '0;
    step();
    step();
    check("midrst pre elem", 64'(elem_o), 64'h02);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    check_outs("midrst after", 0, '0, 0, 1, 0);
    load_valid_i = 1'b1; row_i = r_new;
    step();
    load_valid_i = 1'b0; row_i = '0;
    #1;
    check_outs("midrst reload", 1, 8'h5D, 0, 0, 1);
    repeat (N) step();

    // End-to-end into the consumer shift register
    load_valid_i = 1'b1; ready_i = 1'b1; row_i = r_e2e;
    step();
    load_valid_i = 1'b0; row_i = '0;
    repeat (N) step();
    check("e2e product", 64'(prod), 64'(r_e2e));

    // Random traffic against a queue-of-pending-words model
    pend.delete();
    cur_row = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_i        = ($urandom_range(0, 59) == 0);
      load_valid_i = ($urandom_range(0, 2) != 0);
      ready_i      = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) row_i[k] = NUM_BITS'($urandom());
      #1;
      ev  = (pend.size() > 0);
      ee  = ev ? pend[0] : '0;
      el  = (pend.size() == 1);
      elr = (pend.size() == 0) || (ready_i && pend.size() == 1);
      check_outs($sformatf("rnd%0d", cyc), ev, ee, el, elr, ev);
      fin = 1'b0;
      if (rst_i) begin
        pend.delete();
      end else begin
        fin = ev && ready_i && el;
        if (fin) done_row = cur_row;
        if (ev && ready_i) void'(pend.pop_front());
        if (load_valid_i && elr) begin
          pend.delete();
          for (int k = N - 1; k >= 0; k--) pend.push_back(row_i[k]);
          cur_row = row_i;
        end
      end
      step();
      if (fin) check($sformatf("rnd%0d e2e", cyc), 64'(prod), 64'(done_row));
    end

    rst_i = 1'b0;
    load_valid_i = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
